// File: rtl/fec_frame_tx.sv
// Serial transmitter for 2-D parity FEC frames: sync word, data, row/column
// parity, frame parity and stop bit, one bit per bit_en strobe.
module fec_frame_tx #(
    parameter int         WIDTH = 4,
    parameter int         DEPTH = 4,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0][DEPTH-1:0]  data_in,
    input  logic [DEPTH-1:0]             row_parity,
    input  logic [WIDTH-1:0]             col_parity,
    input  logic                         start,
    input  logic                         bit_en,
    output logic                         tx_out,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun,
    output logic [2:0]                   dbg_state
);

    localparam int N    = WIDTH * DEPTH;
    localparam int PLEN = N + DEPTH + WIDTH;
    localparam int FLEN = PLEN + 10;
    localparam int CW   = $clog2(FLEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_BODY = 3'd2,
        S_FPAR = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [PLEN-1:0] r_shadow;
    logic            r_fpar;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;
    logic            r_ovr;

    // Packed data_in already has flat bit k at data_in[k/DEPTH][k%DEPTH],
    // so the payload in transmit order is a plain concatenation, bit 0 first.
    logic [PLEN-1:0] w_load_vec;
    logic            w_accept;

    assign w_load_vec = {col_parity, row_parity, data_in};
    assign w_accept   = start && ((r_state == S_IDLE) ||
                                  ((r_state == S_STOP) && bit_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_fpar   <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && bit_en;
            r_ovr  <= start && !w_accept;
            if (w_accept) begin
                r_shadow <= w_load_vec;
                r_fpar   <= 1'b0;
                r_cnt    <= '0;
                r_state  <= S_SYNC;
                r_tx     <= SYNC[7];
                r_busy   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    S_SYNC: begin
                        if (bit_en) begin
                            if (r_cnt == CW'(7)) begin
                                r_state <= S_BODY;
                                r_cnt   <= '0;
                                r_tx    <= r_shadow[0];
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                                r_tx  <= SYNC[3'd6 - r_cnt[2:0]];
                            end
                        end
                    end
                    S_BODY: begin
                        // The shadow shifts down so bit 0 is always the bit on the line.
                        if (bit_en) begin
                            r_fpar   <= r_fpar ^ r_shadow[0];
                            r_shadow <= r_shadow >> 1;
                            if (r_cnt == CW'(PLEN - 1)) begin
                                r_state <= S_FPAR;
                                r_cnt   <= '0;
                                r_tx    <= r_fpar ^ r_shadow[0];
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                                r_tx  <= r_shadow[1];
                            end
                        end
                    end
                    S_FPAR: begin
                        if (bit_en) begin
                            r_state <= S_STOP;
                            r_cnt   <= '0;
                            r_tx    <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_en) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign overrun    = r_ovr;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_fec_frame_tx.sv
// Self-checking bench for fec_frame_tx against a bit-list model of the frame.
module tb_fec_frame_tx;

    localparam int W = 4;
    localparam int D = 4;
    localparam int L = W * D + W + D + 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               bit_en;
    logic [W-1:0][D-1:0] data_in;
    logic [D-1:0]       row_parity;
    logic [W-1:0]       col_parity;
    logic               tx_out;
    logic               busy;
    logic               frame_done;
    logic               overrun;
    logic [2:0]         dbg_state;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_q[$];

    fec_frame_tx #(.WIDTH(W), .DEPTH(D), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .row_parity (row_parity),
        .col_parity (col_parity),
        .start      (start),
        .bit_en     (bit_en),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: the bit list written straight from the frame layout.
    task automatic build_exp(input logic [W-1:0][D-1:0] d, input logic [D-1:0] r,
                             input logic [W-1:0] c);
        logic [7:0] sync_v;
        logic       par;
        logic       b;
        sync_v = 8'hA5;
        par    = 1'b0;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(sync_v[i]);
        for (int k = 0; k < W * D; k++) begin
            b = d[k / D][k % D];
            exp_q.push_back(b);
            par = par ^ b;
        end
        for (int i = 0; i < D; i++) begin exp_q.push_back(r[i]); par = par ^ r[i]; end
        for (int i = 0; i < W; i++) begin exp_q.push_back(c[i]); par = par ^ c[i]; end
        exp_q.push_back(par);
        exp_q.push_back(1'b1);
    endtask

    task automatic load(input logic [W-1:0][D-1:0] d, input logic [D-1:0] r,
                        input logic [W-1:0] c);
        data_in    = d;
        row_parity = r;
        col_parity = c;
        start      = 1'b1;
        step();
        start = 1'b0;
        build_exp(d, r, c);
    endtask

    task automatic play(input int period, input int toggle_at, input int ovr_at,
                        input int rst_at, input bit b2b,
                        input logic [W-1:0][D-1:0] nd, input logic [D-1:0] nr,
                        input logic [W-1:0] nc);
        logic ovr_pend;
        bit   last;
        ovr_pend = 1'b0;
        for (int i = 0; i < L; i++) begin
            for (int j = 0; j < period; j++) begin
                if (i == rst_at && j == 0) begin
                    rst = 1'b1;
                    #1;
                    chk("async_rst_tx", tx_out, 1'b1);
                    chk("async_rst_busy", busy, 1'b0);
                    chk("async_rst_done", frame_done, 1'b0);
                    step();
                    rst    = 1'b0;
                    bit_en = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        chk("post_rst_tx", tx_out, 1'b1);
                        chk("post_rst_busy", busy, 1'b0);
                        chk("post_rst_done", frame_done, 1'b0);
                        step();
                    end
                    return;
                end
                chk($sformatf("tx_bit%0d", i), tx_out, exp_q[i]);
                chk("busy_in_frame", busy, 1'b1);
                if (!(i == 0 && j == 0)) chk("done_in_frame", frame_done, 1'b0);
                chk("overrun", overrun, ovr_pend);
                if (i == toggle_at && j == 0) data_in = ~data_in;
                last   = (i == L - 1) && (j == period - 1);
                bit_en = (j == period - 1);
                start  = (i == ovr_at && j == 0) || (b2b && last);
                if (b2b && last) begin
                    data_in    = nd;
                    row_parity = nr;
                    col_parity = nc;
                end
                ovr_pend = start && !(b2b && last);
                step();
                start = 1'b0;
            end
        end
        chk("done_pulse", frame_done, 1'b1);
        chk("overrun_end", overrun, ovr_pend);
        if (b2b) begin
            chk("b2b_busy", busy, 1'b1);
            build_exp(nd, nr, nc);
            chk("b2b_sync7", tx_out, exp_q[0]);
        end else begin
            chk("end_busy", busy, 1'b0);
            chk("end_tx", tx_out, 1'b1);
            step();
            chk("done_clear", frame_done, 1'b0);
            chk("idle_tx", tx_out, 1'b1);
        end
    endtask

    logic [W-1:0][D-1:0] d0;
    logic [W-1:0][D-1:0] d1;
    logic [D-1:0]        r1;
    logic [W-1:0]        c1;

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        bit_en     = 1'b1;
        data_in    = '1;
        row_parity = '1;
        col_parity = '1;
        step();
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_state", dbg_state === 3'd0, 1'b1);
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_tx", tx_out, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ovr", overrun, 1'b0);
        end

        // Single set bit, full-rate then throttled to one bit per 3 cycles.
        d0       = '0;
        d0[0][0] = 1'b1;
        load(d0, 4'b0001, 4'b0001);
        play(1, -1, -1, -1, 1'b0, d0, '0, '0);
        load(d0, 4'b0001, 4'b0001);
        play(3, -1, -1, -1, 1'b0, d0, '0, '0);

        // Back-to-back, then a dropped start at bit 5 of the second frame.
        d1 = (W * D)'($urandom);
        r1 = D'($urandom);
        c1 = W'($urandom);
        load(d0, 4'b0001, 4'b0001);
        play(1, -1, -1, -1, 1'b1, d1, r1, c1);
        play(1, -1, 5, -1, 1'b0, d0, '0, '0);

        // Inputs toggled mid-frame must not leak onto the line.
        load((W * D)'($urandom), D'($urandom), W'($urandom));
        play(2, 12, -1, -1, 1'b0, d0, '0, '0);

        // Reset at bit 20, then a clean frame.
        load((W * D)'($urandom), D'($urandom), W'($urandom));
        play(1, -1, -1, 20, 1'b0, d0, '0, '0);
        load((W * D)'($urandom), D'($urandom), W'($urandom));
        play(1, -1, -1, -1, 1'b0, d0, '0, '0);

        // Random frames with random bit rate and a random dropped start.
        for (int n = 0; n < 6; n++) begin
            load((W * D)'($urandom), D'($urandom), W'($urandom));
            play(int'($urandom_range(1, 4)), int'($urandom_range(8, 23)),
                 int'($urandom_range(0, L - 2)), -1, 1'b0, d0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fec_frame_tx.md
# fec_frame_tx

Serial frame transmitter for the 2-D parity FEC path. It sits between the `encoder` and the physical/serial link, and mirrors the receive-side deframer that feeds the `decoder`. On a `start` strobe (normally the encoder's `done`) it captures the data matrix plus the row and column parity. It then shifts the frame out one bit per `bit_en` strobe: sync word, data, row parity, column parity, frame parity, stop.

## Interface
Parameters:
- `WIDTH`, default 4: columns of the data matrix (column parity bits).
- `DEPTH`, default 4: rows of the data matrix (row parity bits).
- `SYNC`, default 8'hA5: 8-bit sync word, sent MSB first.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `data_in`, input, `[WIDTH-1:0][DEPTH-1:0]`: data matrix, in the same packing as the encoder.
- `row_parity`, input, DEPTH: row parity from the encoder.
- `col_parity`, input, WIDTH: column parity from the encoder.
- `start`, input, 1: load request. Sampled every cycle.
- `bit_en`, input, 1: bit-period strobe. The current bit completes at the end of a cycle with `bit_en`=1.
- `tx_out`, output, 1: serial line. Idles high.
- `busy`, output, 1: a frame is in flight.
- `frame_done`, output, 1: one-cycle pulse when the stop bit completes.
- `overrun`, output, 1: one-cycle pulse when a `start` is dropped.

## Operation
- Frame order, N = WIDTH*DEPTH:
  - 8 sync bits, `SYNC[7]` first.
  - N data bits. Flat bit k = `data_in[k/DEPTH][k%DEPTH]`, k = 0 first.
  - DEPTH row parity bits, bit 0 first.
  - WIDTH column parity bits, bit 0 first.
  - 1 frame parity bit = XOR of all N+DEPTH+WIDTH preceding payload/parity bits (sync excluded).
  - 1 stop bit = 1.
- Total length L = N+DEPTH+WIDTH+10. With the default parameters L = 34.
- FSM states:
  - IDLE: `tx_out`=1, `busy`=0. On `start` → SYNC, with the inputs latched into a shadow register.
  - SYNC: sends 8 bits; after the 8th completing `bit_en` → BODY.
  - BODY: sends data, row parity and column parity, N+DEPTH+WIDTH bits; then → FPAR.
  - FPAR: sends 1 bit; then → STOP.
  - STOP: sends 1 bit. On its completing `bit_en`, `frame_done` pulses next cycle and the state goes → IDLE, or → SYNC on back-to-back.
- Bit counter: width `$clog2(L)`. It resets to 0 on each state entry and increments only on `bit_en`.
- Frame parity:
  - Accumulated serially in BODY.
  - Cleared on load.
- Inputs are used only at load time. Changes to `data_in` or parity mid-frame have no effect on `tx_out`.
- Accept rule: `start` is accepted when `state==IDLE`, or when `state==STOP && bit_en==1` (back-to-back, no idle gap).
- Overrun rule:
  - A `start` arriving in any other busy cycle is dropped and `overrun` pulses the next cycle.
  - The frame in flight is unaffected.
- `bit_en` held low freezes the state, the counter and `tx_out` indefinitely.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `frame_done`=0, `overrun`=0, state=IDLE, shadow register and counter = 0.
- Reset mid-frame:
  - All outputs return to reset values asynchronously.
  - The frame is abandoned; no `frame_done`.
- All outputs are registered.
- Start of frame:
  - `start` accepted at edge E → `busy`=1 and `tx_out`=`SYNC[7]` from E onward.
- Bit progression: each bit stays on `tx_out` until the edge ending a cycle with `bit_en`=1.
- With `bit_en` tied to 1:
  - A frame occupies exactly L cycles.
  - `frame_done` is asserted in the cycle after the stop bit.
  - `busy` falls on the same edge, unless back-to-back.
- Back-to-back frame:
  - `frame_done`=1 and `busy` stays 1.
  - `tx_out` goes directly from the stop bit (1) to the new `SYNC[7]`.
- `start` and `rst` in the same cycle: reset wins.

## Test plan
- **Reset:** assert `rst` with `start`=1 → `tx_out`=1, `busy`=0, no pulses. Release; no activity until `start`.
- **Single-bit frame, `bit_en`=1:** load `data_in` = 0 except `[0][0]`=1, `row_parity`=4'b0001, `col_parity`=4'b0001. Required `tx_out` over 34 cycles: 10100101, then 1 followed by fifteen 0s, then 1000, 1000, then 1 (frame parity), then 1 (stop). `frame_done` pulses at cycle 35.
- **Throttled `bit_en` (1 of every 3 cycles):** each bit is held 3 cycles, 102 cycles total. The bit sequence is identical to the previous scenario.
- **Back-to-back:** raise `start` in the stop-bit cycle → `busy` never drops and the second sync starts immediately. `start` at bit 5 of the second frame → `overrun` pulse; second frame unchanged.
- **Input change mid-frame:** toggle all `data_in` bits at bit 12 → transmitted bits still match the values latched at load.
- **Reset mid-frame:** at bit 20 → `tx_out`=1 and `busy`=0 immediately, no `frame_done`. The next `start` sends a clean frame.
